// File: rtl/synth_env_pkg.sv
// Shared types and widths for the ADSR envelope scheduler.
package synth_env_pkg;

  localparam int unsigned LVL_W  = 7;
  localparam int unsigned TC_W   = 14;
  localparam int unsigned CODE_W = 7;

  localparam logic [LVL_W-1:0] LvlMax = 7'd127;

  typedef enum logic [2:0] {
    StIdle,
    StAttack,
    StDecay,
    StSustain,
    StRelease
  } stage_e;

endpackage

// File: rtl/lin2exp_t.sv
// Exponential time-constant lookup: code 127 is fastest (tc=4), code 0 slowest (tc=992).
module lin2exp_t
  import synth_env_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [TC_W-1:0]   tc_o
);

  logic [CODE_W-1:0] inv;
  logic [TC_W-1:0]   shifted;

  // Invert so larger codes mean shorter times; 16 mantissa steps per octave, rounded /4.
  always_comb begin
    inv     = ~code_i;
    shifted = TC_W'({1'b1, inv[3:0]}) << inv[6:4];
    tc_o    = (shifted + TC_W'(2)) >> 2;
  end

endmodule

// File: rtl/env_rate_sched.sv
// Time-multiplexed ADSR scheduler: one voice read-modify-written per cycle after each
// sample tick, sharing a single lin2exp_t lookup. Results are registered.
module env_rate_sched
  import synth_env_pkg::*;
#(
  parameter int unsigned VOICES = 8,
  parameter int unsigned VW     = $clog2(VOICES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic [VOICES-1:0] gate,
  input  logic [CODE_W-1:0] attack,
  input  logic [CODE_W-1:0] decay,
  input  logic [LVL_W-1:0]  sustain,
  input  logic [CODE_W-1:0] release_code,
  output logic              env_valid,
  output logic [VW-1:0]     env_voice,
  output logic [LVL_W-1:0]  env_level,
  output logic              busy,
  output logic              overrun
);

  stage_e            stage_q [VOICES];
  logic [LVL_W-1:0]  level_q [VOICES];
  logic [TC_W-1:0]   cnt_q   [VOICES];
  logic [VOICES-1:0] pgate_q;

  logic              busy_q, busy_d;
  logic [VW-1:0]     vidx_q, vidx_d;
  logic [VOICES-1:0] snap_q, snap_d;
  logic              env_valid_q, env_valid_d;
  logic [VW-1:0]     env_voice_q, env_voice_d;
  logic [LVL_W-1:0]  env_level_q, env_level_d;
  logic              overrun_q, overrun_d;

  stage_e            cur_stage, stage_d;
  logic [LVL_W-1:0]  cur_lvl, level_d, lvl_up, lvl_dn;
  logic [TC_W-1:0]   cur_cnt, cnt_d;
  logic [TC_W:0]     cnt_inc;
  logic              cur_pg, cur_sn, rate_step;
  logic [CODE_W-1:0] code_sel;
  logic [TC_W-1:0]   tc;

  lin2exp_t u_lin2exp (
    .code_i (code_sel),
    .tc_o   (tc)
  );

  // Sweep sequencing
  always_comb begin
    busy_d    = busy_q;
    vidx_d    = vidx_q;
    snap_d    = snap_q;
    overrun_d = sample_tick & busy_q;
    if (!busy_q) begin
      if (sample_tick) begin
        busy_d = 1'b1;
        vidx_d = '0;
        snap_d = gate;
      end
    end else begin
      vidx_d = vidx_q + VW'(1);
      if (vidx_q == VW'(VOICES - 1)) busy_d = 1'b0;
    end
  end

  // Per-voice envelope update for the voice under the sweep pointer
  always_comb begin
    cur_stage = stage_q[vidx_q];
    cur_lvl   = level_q[vidx_q];
    cur_cnt   = cnt_q[vidx_q];
    cur_pg    = pgate_q[vidx_q];
    cur_sn    = snap_q[vidx_q];

    case (cur_stage)
      StDecay:   code_sel = decay;
      StRelease: code_sel = release_code;
      default:   code_sel = attack;
    endcase

    cnt_inc   = {1'b0, cur_cnt} + (TC_W+1)'(1);
    rate_step = cnt_inc >= {1'b0, tc};
    lvl_up    = (cur_lvl == LvlMax) ? LvlMax : cur_lvl + LVL_W'(1);
    lvl_dn    = (cur_lvl == '0) ? '0 : cur_lvl - LVL_W'(1);

    stage_d = cur_stage;
    level_d = cur_lvl;
    cnt_d   = rate_step ? '0 : cnt_inc[TC_W-1:0];

    if (cur_sn && !cur_pg) begin
      stage_d = StAttack;
      cnt_d   = '0;
    end else if (!cur_sn && cur_pg && cur_stage != StIdle) begin
      stage_d = StRelease;
      cnt_d   = '0;
    end else begin
      case (cur_stage)
        StAttack: begin
          if (rate_step) begin
            level_d = lvl_up;
            if (lvl_up == LvlMax) stage_d = (sustain == LvlMax) ? StSustain : StDecay;
          end
        end
        StDecay: begin
          if (cur_lvl <= sustain) begin
            stage_d = StSustain;
            cnt_d   = '0;
          end else if (rate_step) begin
            level_d = lvl_dn;
            if (lvl_dn <= sustain) stage_d = StSustain;
          end
        end
        StSustain: begin
          level_d = sustain;
          cnt_d   = '0;
        end
        StRelease: begin
          if (rate_step) begin
            level_d = lvl_dn;
            if (lvl_dn == '0) stage_d = StIdle;
          end
        end
        default: begin
          stage_d = StIdle;
          level_d = '0;
          cnt_d   = '0;
        end
      endcase
    end

    env_valid_d = busy_q;
    env_voice_d = busy_q ? vidx_q : '0;
    env_level_d = busy_q ? level_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= 1'b0;
      vidx_q      <= '0;
      snap_q      <= '0;
      env_valid_q <= 1'b0;
      env_voice_q <= '0;
      env_level_q <= '0;
      overrun_q   <= 1'b0;
      pgate_q     <= '0;
      for (int i = 0; i < int'(VOICES); i++) begin
        stage_q[i] <= StIdle;
        level_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      vidx_q      <= vidx_d;
      snap_q      <= snap_d;
      env_valid_q <= env_valid_d;
      env_voice_q <= env_voice_d;
      env_level_q <= env_level_d;
      overrun_q   <= overrun_d;
      if (busy_q) begin
        stage_q[vidx_q] <= stage_d;
        level_q[vidx_q] <= level_d;
        cnt_q[vidx_q]   <= cnt_d;
        pgate_q[vidx_q] <= cur_sn;
      end
    end
  end

  assign env_valid = env_valid_q;
  assign env_voice = env_voice_q;
  assign env_level = env_level_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_env_rate_sched.sv
// Scoreboard bench for env_rate_sched: a per-voice ADSR model queues expected results,
// a negedge monitor compares them against the streamed outputs.
module tb_env_rate_sched;

  localparam int V = 8;
  localparam int M_IDLE = 0, M_ATT = 1, M_DEC = 2, M_SUS = 3, M_REL = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sample_tick = 1'b0;
  logic [V-1:0] gate = '0;
  logic [6:0]   attack = '0, decay = '0, sustain = '0, release_code = '0;
  logic         env_valid, busy, overrun;
  logic [2:0]   env_voice;
  logic [6:0]   env_level;

  env_rate_sched #(.VOICES(V)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_tick  (sample_tick),
    .gate         (gate),
    .attack       (attack),
    .decay        (decay),
    .sustain      (sustain),
    .release_code (release_code),
    .env_valid    (env_valid),
    .env_voice    (env_voice),
    .env_level    (env_level),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_voice[$];
  int exp_level[$];
  int last_lvl[V];
  int m_st[V], m_lvl[V], m_cnt[V];
  bit m_pg[V];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Time constant: 16 steps per doubling, 4 ticks at the fastest code.
  function automatic int tc_of(input int code);
    int i;
    i = 127 - code;
    return ((16 + (i % 16)) * (1 << (i / 16)) + 2) / 4;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < V; v++) begin
      m_st[v] = M_IDLE; m_lvl[v] = 0; m_cnt[v] = 0; m_pg[v] = 1'b0;
    end
  endtask

  task automatic model_sweep();
    int sus;
    sus = int'(sustain);
    for (int v = 0; v < V; v++) begin
      bit sn;
      sn = gate[v];
      if (sn && !m_pg[v]) begin
        m_st[v] = M_ATT; m_cnt[v] = 0;
      end else if (!sn && m_pg[v] && m_st[v] != M_IDLE) begin
        m_st[v] = M_REL; m_cnt[v] = 0;
      end else begin
        case (m_st[v])
          M_ATT: begin
            if (m_cnt[v] + 1 >= tc_of(int'(attack))) begin
              m_cnt[v] = 0;
              if (m_lvl[v] < 127) m_lvl[v]++;
              if (m_lvl[v] == 127) m_st[v] = (sus == 127) ? M_SUS : M_DEC;
            end else m_cnt[v]++;
          end
          M_DEC: begin
            if (m_lvl[v] <= sus) begin
              m_st[v] = M_SUS; m_cnt[v] = 0;
            end else if (m_cnt[v] + 1 >= tc_of(int'(decay))) begin
              m_cnt[v] = 0;
              m_lvl[v]--;
              if (m_lvl[v] <= sus) m_st[v] = M_SUS;
            end else m_cnt[v]++;
          end
          M_SUS: begin
            m_lvl[v] = sus; m_cnt[v] = 0;
          end
          M_REL: begin
            if (m_cnt[v] + 1 >= tc_of(int'(release_code))) begin
              m_cnt[v] = 0;
              if (m_lvl[v] > 0) m_lvl[v]--;
              if (m_lvl[v] == 0) m_st[v] = M_IDLE;
            end else m_cnt[v]++;
          end
          default: begin
            m_lvl[v] = 0; m_cnt[v] = 0;
          end
        endcase
      end
      m_pg[v] = sn;
      exp_voice.push_back(v);
      exp_level.push_back(m_lvl[v]);
    end
  endtask

  // Monitor: every env_valid consumes one expected entry.
  always @(negedge clk) begin
    if (env_valid) begin
      if (exp_voice.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got voice %0d level %0d, expected no result",
                 env_voice, env_level);
      end else begin
        int ev, el;
        ev = exp_voice.pop_front();
        el = exp_level.pop_front();
        check("env_voice", int'(env_voice), ev);
        check("env_level", int'(env_level), el);
        last_lvl[env_voice] = int'(env_level);
      end
    end
  end

  // Called at posedge+1 with busy low; checks the busy/valid window of the sweep.
  task automatic run_tick();
    int busy_bad, valid_bad;
    busy_bad = 0;
    valid_bad = 0;
    sample_tick = 1'b1;
    model_sweep();
    @(posedge clk);
    #1 sample_tick = 1'b0;
    for (int k = 1; k <= V + 2; k++) begin
      @(negedge clk);
      if (busy !== (k <= V)) busy_bad++;
      if (env_valid !== (k >= 2 && k <= V + 1)) valid_bad++;
    end
    check("busy_window", busy_bad, 0);
    check("valid_window", valid_bad, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) run_tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nval, ovr_bad, stray_v, stray_b;
    model_reset();
    for (int v = 0; v < V; v++) last_lvl[v] = -1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_env_valid", int'(env_valid), 0);
    check("rst_env_voice", int'(env_voice), 0);
    check("rst_env_level", int'(env_level), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    @(posedge clk);
    #1;

    // Attack to peak, decay to sustain, sustain tracking
    attack = 7'd127; decay = 7'd127; sustain = 7'd64; release_code = 7'd120;
    gate = 8'h01;
    run_ticks(4);   check("atk_tick4", last_lvl[0], 0);
    run_ticks(1);   check("atk_tick5", last_lvl[0], 1);
    run_ticks(504); check("atk_tick509", last_lvl[0], 127);
    run_ticks(251); check("dec_tick760", last_lvl[0], 65);
    run_ticks(1);   check("dec_tick761", last_lvl[0], 64);
    run_ticks(4);   check("sus_hold", last_lvl[0], 64);
    sustain = 7'd40;  run_tick(); check("sus_to_40", last_lvl[0], 40);
    sustain = 7'd100; run_tick(); check("sus_to_100", last_lvl[0], 100);
    sustain = 7'd64;  run_tick(); check("sus_to_64", last_lvl[0], 64);

    // Release, retrigger mid-release, release to idle
    gate = 8'h00;
    run_ticks(1);   check("rel_edge", last_lvl[0], 64);
    run_ticks(6);   check("rel_first_step", last_lvl[0], 63);
    run_ticks(54);  check("rel_60", last_lvl[0], 54);
    gate = 8'h01;
    run_ticks(5);   check("retrig_step", last_lvl[0], 55);
    gate = 8'h00;
    run_ticks(331); check("rel_to_zero", last_lvl[0], 0);

    // All voices rise on one tick
    gate = '1;
    run_tick();

    // Randomised gates and codes
    for (int n = 0; n < 300; n++) begin
      for (int b = 0; b < V; b++) if ($urandom_range(7) == 0) gate[b] = ~gate[b];
      attack = 7'($urandom_range(127, 100));
      decay = 7'($urandom_range(127, 100));
      release_code = 7'($urandom_range(127, 100));
      if ($urandom_range(15) == 0) sustain = 7'($urandom_range(127, 0));
      run_tick();
    end

    // Ticks at T+3 and in the final sweep cycle are dropped with overrun
    nval = 0;
    ovr_bad = 0;
    sample_tick = 1'b1;
    model_sweep();
    @(posedge clk);
    #1;
    for (int k = 1; k <= 2 * V + 4; k++) begin
      sample_tick = (k == 3 || k == V);
      @(negedge clk);
      if (env_valid) nval++;
      if (overrun !== (k == 4 || k == V + 1)) ovr_bad++;
      @(posedge clk);
      #1;
    end
    sample_tick = 1'b0;
    check("ovr_single_sweep", nval, V);
    check("ovr_pulses", ovr_bad, 0);

    // Reset mid-sweep
    gate = 8'hA5;
    sample_tick = 1'b1;
    model_sweep();
    @(posedge clk);
    #1 sample_tick = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 sample_tick = 1'b1;
    @(negedge clk);
    check("ovr_t3", int'(overrun), 0);
    @(posedge clk);
    #1 sample_tick = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("ovr_t4", int'(overrun), 1);
    check("busy_t4", int'(busy), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    stray_v = 0;
    stray_b = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (env_valid) stray_v++;
      if (busy) stray_b++;
    end
    check("rst_no_valid", stray_v, 0);
    check("rst_no_busy", stray_b, 0);
    check("rst_results_seen", V - exp_voice.size(), 3);
    exp_voice.delete();
    exp_level.delete();
    model_reset();
    @(posedge clk);
    #1;
    gate = '0;
    for (int v = 0; v < V; v++) last_lvl[v] = -1;
    run_tick();
    check("post_rst_v0", last_lvl[0], 0);
    check("post_rst_v7", last_lvl[V-1], 0);

    check("queue_drained", exp_voice.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
